ddr3_iod_dly_stepper: RTL and testbench
=======================================

Name: ddr3_iod_dly_stepper

Overview:
- Fabric-side controller that drives the dynamic delay-line controls (load/move/direction) of one DDR3 address/command IOD lane.
- Consumes the lane's out-of-range flag.
- Accepts "go to tap N" requests from the training/calibration sequencer, issues spaced single-cycle move pulses, and tracks the current tap count.
- One instance per address/command lane; sits directly upstream of the lane IOD wrapper.

Parameters:
- TAP_W, 8, width of tap counter and target.
- INIT_TAP, 1, tap value the delay line holds after a LOAD pulse.
- MOVE_GAP, 3, idle cycles (≥1) after each LOAD/MOVE pulse before the next decision.

Ports:
- FAB_CLK  in  1  fabric clock; all logic is on the rising edge.
- ARST_N  in  1  reset, asynchronous assert, active-low.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request accepted when VALID&READY.
- REQ_TARGET  in  TAP_W  requested final tap.
- REQ_LOAD  in  1  when 1, issue LOAD (tap←INIT_TAP) before stepping.
- ABORT  in  1  stop the current request at the next decision point.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid with DONE; 1 = out-of-range/saturation stop.
- CUR_TAP  out  TAP_W  current tap count as tracked.
- DELAY_LINE_LOAD_0  out  1  to IOD.
- DELAY_LINE_MOVE_0  out  1  to IOD.
- DELAY_LINE_DIRECTION_0  out  1  to IOD; 1 = increment.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  from IOD.

Behaviour:
- Reset (ARST_N=0, async) values:
  - State IDLE, REQ_READY=1, DONE=0, ERR=0.
  - CUR_TAP=INIT_TAP.
  - LOAD/MOVE/DIRECTION=0.
  - Gap counter 0, latched target 0.
- Reset mid-operation aborts immediately to the reset values; no pulse completes.
- All outputs are registered and driven by state only.
- States:
  - IDLE: REQ_READY=1. On VALID&READY, latch REQ_TARGET and REQ_LOAD; go to LOAD if REQ_LOAD=1, else STEP. REQ_READY=0 in every other state.
  - LOAD: 1 cycle with DELAY_LINE_LOAD_0=1; CUR_TAP←INIT_TAP; go to GAP.
  - STEP (1-cycle decision):
    - ABORT=1 → DONE with ERR=0.
    - CUR_TAP==target → DONE with ERR=0.
    - Target>CUR_TAP and CUR_TAP==all-ones → DONE with ERR=1.
    - Target<CUR_TAP and CUR_TAP==0 → DONE with ERR=1.
    - Otherwise set DIRECTION (1 if target>CUR_TAP) and go to MOVE.
  - MOVE: 1 cycle with MOVE=1. DIRECTION is unchanged from the STEP cycle and holds its last value until the next STEP decision. CUR_TAP ±1 (no wrap) at the end of the cycle. Go to GAP.
  - GAP: MOVE_GAP cycles, all pulses 0. OUT_OF_RANGE is sampled each GAP cycle that follows a MOVE; if 1 in any cycle:
    - CUR_TAP reverts by one step;
    - next state is DONE with ERR=1.
    - Otherwise, after MOVE_GAP cycles, go to STEP.
  - DONE: 1 cycle with DONE=1, ERR as decided; next state IDLE. ERR=0 whenever DONE=0.
- OUT_OF_RANGE is ignored in IDLE, LOAD, the GAP following LOAD, STEP and DONE.
- ABORT is sampled only in STEP. ABORT never cuts a pulse or gap short. If OUT_OF_RANGE and ABORT are pending together, ERR=1 wins.
- Latency: cycle 0 is the first cycle after acceptance; G=MOVE_GAP; N=|target−start|. DONE is high in cycle L·(1+G)+N·(2+G)+1, where L=REQ_LOAD.
- No back-to-back acceptance: the earliest next acceptance is the cycle after DONE.
- At most one MOVE pulse per 2+G cycles.
- LOAD and MOVE are never high together.

Test Plan:
- Reset: ARST_N low mid-GAP with G=3 → all outputs immediately at reset values; CUR_TAP=1; REQ_READY=1.
- Step up: no load, CUR_TAP=1, target 4, G=3 → 3 MOVE pulses with DIRECTION=1, 5 cycles apart; DONE in cycle 16; ERR=0; CUR_TAP=4.
- Load only: REQ_LOAD=1, target 1, CUR_TAP=9 → LOAD in cycle 0; DONE in cycle 5; CUR_TAP=1; no MOVE.
- Step down then up: from 4 to 2 → 2 moves with DIRECTION=0. Then request 3 → DIRECTION=1 seen at STEP, held through MOVE.
- Out-of-range: target 10, IOD raises OUT_OF_RANGE in the 2nd GAP cycle after the 6th move (CUR_TAP 7) → DONE with ERR=1; CUR_TAP=6; no further MOVE.
- Saturation and abort:
  - CUR_TAP=255, target 0 then 255 to an idle lane at 0 → correct step counts, no wrap.
  - ABORT held during a 4-step request → DONE with ERR=0 at the first STEP after the current gap.

Source files
------------

// File: rtl/ddr3_iod_dly_stepper.sv
// Tap stepper for one DDR3 address/command IOD delay line: accepts "go to tap N"
// requests, issues spaced LOAD/MOVE pulses and tracks the current tap count.
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | one-cycle LOAD pulse, tap returns to INIT_TAP
// STEP  | one-cycle decision: finish, saturate, or move
// MOVE  | one-cycle MOVE pulse in the held direction
// GAP   | MOVE_GAP quiet cycles; out-of-range is checked after a MOVE
// DONE  | one-cycle completion pulse with ERR
module ddr3_iod_dly_stepper #(
  parameter int TAP_W    = 8,
  parameter int INIT_TAP = 1,
  parameter int MOVE_GAP = 3
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [TAP_W-1:0] REQ_TARGET,
  input  logic             REQ_LOAD,
  input  logic             ABORT,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] CUR_TAP,
  output logic             DELAY_LINE_LOAD_0,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

  localparam int GW = (MOVE_GAP < 2) ? 1 : $clog2(MOVE_GAP + 1);
  localparam logic [GW-1:0]    GAP_INIT = GW'(MOVE_GAP - 1);
  localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] TAP_MAX  = {TAP_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_STEP = 3'd2,
    S_MOVE = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [TAP_W-1:0] tgt_q, tgt_d;
  logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
  logic             after_move_q, after_move_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             load_q, load_d;
  logic             move_q, move_d;

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    tgt_d        = tgt_q;
    cur_tap_d    = cur_tap_q;
    after_move_d = after_move_q;
    dir_d        = dir_q;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          tgt_d = REQ_TARGET;
          if (REQ_LOAD) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_STEP;
            // direction is presented during the STEP cycle that may use it
            if (REQ_TARGET > cur_tap_q)      dir_d = 1'b1;
            else if (REQ_TARGET < cur_tap_q) dir_d = 1'b0;
          end
        end
      end
      S_LOAD: begin
        cur_tap_d    = TAP_INIT;
        gap_d        = GAP_INIT;
        after_move_d = 1'b0;
        state_d      = S_GAP;
      end
      S_STEP: begin
        if (ABORT || (cur_tap_q == tgt_q)) begin
          state_d = S_DONE;
        end else if ((tgt_q > cur_tap_q) && (cur_tap_q == TAP_MAX)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if ((tgt_q < cur_tap_q) && (cur_tap_q == '0)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (dir_q && (cur_tap_q != TAP_MAX))    cur_tap_d = cur_tap_q + TAP_W'(1);
        else if (!dir_q && (cur_tap_q != '0))   cur_tap_d = cur_tap_q - TAP_W'(1);
        gap_d        = GAP_INIT;
        after_move_d = 1'b1;
        state_d      = S_GAP;
      end
      S_GAP: begin
        if (after_move_q && DELAY_LINE_OUT_OF_RANGE_0) begin
          // the IOD refused the last move, so undo it in the tracked count
          cur_tap_d = dir_q ? (cur_tap_q - TAP_W'(1)) : (cur_tap_q + TAP_W'(1));
          state_d   = S_DONE;
          err_d     = 1'b1;
        end else if (gap_q == '0) begin
          state_d = S_STEP;
          if (tgt_q > cur_tap_q)      dir_d = 1'b1;
          else if (tgt_q < cur_tap_q) dir_d = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
    load_d  = (state_d == S_LOAD);
    move_d  = (state_d == S_MOVE);
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q      <= S_IDLE;
      gap_q        <= '0;
      tgt_q        <= '0;
      cur_tap_q    <= TAP_INIT;
      after_move_q <= 1'b0;
      dir_q        <= 1'b0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      load_q       <= 1'b0;
      move_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      tgt_q        <= tgt_d;
      cur_tap_q    <= cur_tap_d;
      after_move_q <= after_move_d;
      dir_q        <= dir_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      load_q       <= load_d;
      move_q       <= move_d;
    end
  end

  assign REQ_READY              = ready_q;
  assign DONE                   = done_q;
  assign ERR                    = err_q;
  assign CUR_TAP                = cur_tap_q;
  assign DELAY_LINE_LOAD_0      = load_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;

endmodule

// File: tb/tb_ddr3_iod_dly_stepper.sv
// Directed bench for ddr3_iod_dly_stepper with MOVE_GAP=3, INIT_TAP=1, TAP_W=8.
module tb_ddr3_iod_dly_stepper;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       req_valid, req_ready, req_load, abort_i;
  logic [7:0] req_target, cur_tap;
  logic       done, err, dl_load, dl_move, dl_dir, dl_oor;

  int tests = 0;
  int fails = 0;

  int done_cyc, err_at_done, moves, first_move, load_cyc;
  int dir_bad, spacing_bad, overlap_bad, err_bad;

  always #5 clk = ~clk;

  ddr3_iod_dly_stepper #(.TAP_W(8), .INIT_TAP(1), .MOVE_GAP(3)) dut (
    .FAB_CLK                   (clk),
    .ARST_N                    (arst_n),
    .REQ_VALID                 (req_valid),
    .REQ_READY                 (req_ready),
    .REQ_TARGET                (req_target),
    .REQ_LOAD                  (req_load),
    .ABORT                     (abort_i),
    .DONE                      (done),
    .ERR                       (err),
    .CUR_TAP                   (cur_tap),
    .DELAY_LINE_LOAD_0         (dl_load),
    .DELAY_LINE_MOVE_0         (dl_move),
    .DELAY_LINE_DIRECTION_0    (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE_0 (dl_oor)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request; cycle 0 is the first cycle after acceptance, sampled at negedge.
  task automatic run_req(input logic [7:0] tgt, input logic ld, input logic exp_dir,
                         input int oor_mv, input int oor_gap, input int abort_at);
    int  mv_last;
    logic prev_dir;
    done_cyc = -1; err_at_done = -1; moves = 0; first_move = -1; load_cyc = -1;
    dir_bad = 0; mv_last = -100;
    @(negedge clk);
    chk("ready_before_req", int'(req_ready), 1);
    req_valid = 1'b1; req_target = tgt; req_load = ld;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_low_cycle0", int'(req_ready), 0);
    prev_dir = dl_dir;
    for (int c = 0; c < 1400; c++) begin
      if (dl_move) begin
        moves++;
        if (moves == 1) first_move = c;
        if (moves > 1 && (c - mv_last) < 5) spacing_bad++;
        if (dl_dir !== exp_dir || prev_dir !== exp_dir) dir_bad++;
        mv_last = c;
      end
      if (dl_load) load_cyc = c;
      if (dl_load && dl_move) overlap_bad++;
      if (!done && err) err_bad++;
      if (done) begin
        done_cyc = c;
        err_at_done = int'(err);
        break;
      end
      dl_oor  = (oor_mv > 0) && (moves == oor_mv) && (c == mv_last + oor_gap);
      abort_i = (abort_at >= 0) && (c >= abort_at);
      prev_dir = dl_dir;
      @(negedge clk);
    end
    dl_oor = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    chk("ready_after_done", int'(req_ready), 1);
    chk("err_low_after_done", int'(err), 0);
  endtask

  initial begin
    arst_n = 1'b0; req_valid = 1'b0; req_target = 8'd0; req_load = 1'b0;
    abort_i = 1'b0; dl_oor = 1'b0;
    spacing_bad = 0; overlap_bad = 0; err_bad = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cur_tap", int'(cur_tap), 1);
    chk("rst_pulses", int'({dl_load, dl_move, dl_dir}), 0);
    arst_n = 1'b1;

    // step up 1 -> 4
    run_req(8'd4, 1'b0, 1'b1, 0, 0, -1);
    chk("up_moves", moves, 3);
    chk("up_first_move", first_move, 1);
    chk("up_done_cyc", done_cyc, 16);
    chk("up_err", err_at_done, 0);
    chk("up_cur", int'(cur_tap), 4);
    chk("up_dir", dir_bad, 0);

    // step down 4 -> 2, then up 2 -> 3 (direction visible in STEP)
    run_req(8'd2, 1'b0, 1'b0, 0, 0, -1);
    chk("down_moves", moves, 2);
    chk("down_done_cyc", done_cyc, 11);
    chk("down_cur", int'(cur_tap), 2);
    chk("down_dir", dir_bad, 0);
    run_req(8'd3, 1'b0, 1'b1, 0, 0, -1);
    chk("reup_moves", moves, 1);
    chk("reup_done_cyc", done_cyc, 6);
    chk("reup_dir", dir_bad, 0);

    // to 9, then load only back to 1
    run_req(8'd9, 1'b0, 1'b1, 0, 0, -1);
    chk("to9_done_cyc", done_cyc, 31);
    chk("to9_cur", int'(cur_tap), 9);
    run_req(8'd1, 1'b1, 1'b0, 0, 0, -1);
    chk("load_cyc", load_cyc, 0);
    chk("load_done_cyc", done_cyc, 5);
    chk("load_moves", moves, 0);
    chk("load_cur", int'(cur_tap), 1);

    // out-of-range in 2nd gap cycle after 6th move
    run_req(8'd10, 1'b0, 1'b1, 6, 2, -1);
    chk("oor_moves", moves, 6);
    chk("oor_done_cyc", done_cyc, 29);
    chk("oor_err", err_at_done, 1);
    chk("oor_cur", int'(cur_tap), 6);

    // abort during a 4-step request
    run_req(8'd10, 1'b0, 1'b1, 0, 0, 2);
    chk("abort_moves", moves, 1);
    chk("abort_done_cyc", done_cyc, 6);
    chk("abort_err", err_at_done, 0);
    chk("abort_cur", int'(cur_tap), 7);

    // abort and out-of-range pending together: error wins
    run_req(8'd9, 1'b0, 1'b1, 1, 2, 2);
    chk("abort_oor_done_cyc", done_cyc, 4);
    chk("abort_oor_err", err_at_done, 1);
    chk("abort_oor_cur", int'(cur_tap), 7);

    // reset mid-GAP
    @(negedge clk);
    req_valid = 1'b1; req_target = 8'd9; req_load = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_dir", int'(dl_dir), 1);
    #1 arst_n = 1'b0;
    #1;
    chk("midrst_cur", int'(cur_tap), 1);
    chk("midrst_ready", int'(req_ready), 1);
    chk("midrst_outs", int'({done, err, dl_load, dl_move, dl_dir}), 0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("postrst_idle", int'({req_ready, cur_tap}), 257);

    // saturation walk, no wrap
    run_req(8'd255, 1'b0, 1'b1, 0, 0, -1);
    chk("sat_up_moves", moves, 254);
    chk("sat_up_done_cyc", done_cyc, 1271);
    chk("sat_up_cur", int'(cur_tap), 255);
    run_req(8'd0, 1'b0, 1'b0, 0, 0, -1);
    chk("sat_dn_moves", moves, 255);
    chk("sat_dn_cur", int'(cur_tap), 0);
    chk("sat_dn_dir", dir_bad, 0);
    run_req(8'd255, 1'b0, 1'b1, 0, 0, -1);
    chk("sat_up2_moves", moves, 255);
    chk("sat_up2_done_cyc", done_cyc, 1276);
    chk("sat_up2_cur", int'(cur_tap), 255);

    // load followed by steps
    run_req(8'd3, 1'b1, 1'b1, 0, 0, -1);
    chk("ldstep_load_cyc", load_cyc, 0);
    chk("ldstep_moves", moves, 2);
    chk("ldstep_done_cyc", done_cyc, 15);
    chk("ldstep_cur", int'(cur_tap), 3);

    chk("move_spacing", spacing_bad, 0);
    chk("load_move_overlap", overlap_bad, 0);
    chk("err_without_done", err_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
